// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
// Holds the bit-level FSM encoding, scan-code prefixes and default key map.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_e;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  localparam logic [7:0] KEY_LEFT  = 8'h6B;
  localparam logic [7:0] KEY_RIGHT = 8'h74;
  localparam logic [7:0] KEY_ESC   = 8'h76;
  localparam logic [7:0] KEY_SPACE = 8'h29;

  // PS/2 frames carry odd parity over the data byte plus the parity bit
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchronizer plus run-length glitch filter for the PS/2 clock pin.
// The clean level only moves after FILTER_LEN consecutive disagreeing samples.
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic line,
  output logic level,
  output logic fall
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic          sync1_r;
  logic          sync2_r;
  logic          level_r;
  logic          fall_r;
  logic [CW-1:0] run_cnt_r;

  // Synchronize the pin, count disagreeing samples and flip the level on a full run
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_r   <= 1'b1;
      sync2_r   <= 1'b1;
      level_r   <= 1'b1;
      fall_r    <= 1'b0;
      run_cnt_r <= {CW{1'b0}};
    end else begin
      sync1_r <= line;
      sync2_r <= sync1_r;
      fall_r  <= 1'b0;
      if (sync2_r == level_r) begin
        run_cnt_r <= {CW{1'b0}};
      end else if (run_cnt_r == CW'(FILTER_LEN - 1)) begin
        level_r   <= sync2_r;
        fall_r    <= level_r;
        run_cnt_r <= {CW{1'b0}};
      end else begin
        run_cnt_r <= run_cnt_r + CW'(1);
      end
    end
  end

  assign level = level_r;
  assign fall  = fall_r;

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: frames scan-code set 2 bytes, tracks E0/F0 prefixes
// and turns four mapped keys into held button levels for the game logic.
module ps2_keyboard_rx
  import ps2_pkg::*;
#(
  parameter int         FILTER_LEN     = 8,
  parameter int         TIMEOUT_CYCLES = 50000,
  parameter logic [7:0] KEY_A_CODE     = KEY_LEFT,
  parameter logic       KEY_A_EXT      = 1'b1,
  parameter logic [7:0] KEY_B_CODE     = KEY_RIGHT,
  parameter logic       KEY_B_EXT      = 1'b1,
  parameter logic [7:0] KEY_C_CODE     = KEY_ESC,
  parameter logic       KEY_C_EXT      = 1'b0,
  parameter logic [7:0] KEY_D_CODE     = KEY_SPACE,
  parameter logic       KEY_D_EXT      = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_break,
  output logic       key_valid,
  output logic       frame_err,
  output logic       btn_A,
  output logic       btn_B,
  output logic       btn_C,
  output logic       btn_D
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);

  logic          clk_level_s;
  logic          fall_s;
  logic          data_s1_r;
  logic          data_s2_r;
  ps2_state_e    state_r;
  logic [7:0]    shift_r;
  logic [2:0]    bit_cnt_r;
  logic          par_r;
  logic [TW-1:0] to_cnt_r;
  logic          ext_pend_r;
  logic          brk_pend_r;
  logic [7:0]    key_code_r;
  logic          key_ext_r;
  logic          key_break_r;
  logic          key_valid_r;
  logic          frame_err_r;
  logic          btn_a_r;
  logic          btn_b_r;
  logic          btn_c_r;
  logic          btn_d_r;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .clk   (clk),
    .reset (reset),
    .line  (ps2_clk),
    .level (clk_level_s),
    .fall  (fall_s)
  );

  // Data pin only needs synchronizing; the keyboard holds it stable around the clock fall
  always_ff @(posedge clk) begin
    if (reset) begin
      data_s1_r <= 1'b1;
      data_s2_r <= 1'b1;
    end else begin
      data_s1_r <= ps2_data;
      data_s2_r <= data_s1_r;
    end
  end

  // Bit framing, timeout, prefix tracking and key/button decode
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      shift_r     <= 8'h00;
      bit_cnt_r   <= 3'd0;
      par_r       <= 1'b0;
      to_cnt_r    <= {TW{1'b0}};
      ext_pend_r  <= 1'b0;
      brk_pend_r  <= 1'b0;
      key_code_r  <= 8'h00;
      key_ext_r   <= 1'b0;
      key_break_r <= 1'b0;
      key_valid_r <= 1'b0;
      frame_err_r <= 1'b0;
      btn_a_r     <= 1'b0;
      btn_b_r     <= 1'b0;
      btn_c_r     <= 1'b0;
      btn_d_r     <= 1'b0;
    end else begin
      key_valid_r <= 1'b0;
      frame_err_r <= 1'b0;

      if (state_r == ST_IDLE || fall_s) begin
        to_cnt_r <= {TW{1'b0}};
      end else begin
        to_cnt_r <= to_cnt_r + TW'(1);
      end

      // A fall in the same cycle as expiry takes priority over the timeout
      if (fall_s) begin
        case (state_r)
          ST_IDLE: begin
            if (!data_s2_r) begin
              state_r   <= ST_DATA;
              bit_cnt_r <= 3'd0;
            end else begin
              frame_err_r <= 1'b1;
              ext_pend_r  <= 1'b0;
              brk_pend_r  <= 1'b0;
            end
          end
          ST_DATA: begin
            shift_r   <= {data_s2_r, shift_r[7:1]};
            bit_cnt_r <= bit_cnt_r + 3'd1;
            if (bit_cnt_r == 3'd7) begin
              state_r <= ST_PARITY;
            end
          end
          ST_PARITY: begin
            par_r   <= data_s2_r;
            state_r <= ST_STOP;
          end
          ST_STOP: begin
            state_r <= ST_IDLE;
            if (data_s2_r && odd_parity_ok(shift_r, par_r)) begin
              if (shift_r == PS2_EXT) begin
                ext_pend_r <= 1'b1;
              end else if (shift_r == PS2_BRK) begin
                brk_pend_r <= 1'b1;
              end else begin
                key_code_r  <= shift_r;
                key_ext_r   <= ext_pend_r;
                key_break_r <= brk_pend_r;
                key_valid_r <= 1'b1;
                ext_pend_r  <= 1'b0;
                brk_pend_r  <= 1'b0;
                if ({ext_pend_r, shift_r} == {KEY_A_EXT, KEY_A_CODE}) btn_a_r <= ~brk_pend_r;
                if ({ext_pend_r, shift_r} == {KEY_B_EXT, KEY_B_CODE}) btn_b_r <= ~brk_pend_r;
                if ({ext_pend_r, shift_r} == {KEY_C_EXT, KEY_C_CODE}) btn_c_r <= ~brk_pend_r;
                if ({ext_pend_r, shift_r} == {KEY_D_EXT, KEY_D_CODE}) btn_d_r <= ~brk_pend_r;
              end
            end else begin
              frame_err_r <= 1'b1;
              ext_pend_r  <= 1'b0;
              brk_pend_r  <= 1'b0;
            end
          end
          default: state_r <= ST_IDLE;
        endcase
      end else if (state_r != ST_IDLE && to_cnt_r == TW'(TIMEOUT_CYCLES - 1)) begin
        state_r     <= ST_IDLE;
        frame_err_r <= 1'b1;
        ext_pend_r  <= 1'b0;
        brk_pend_r  <= 1'b0;
      end
    end
  end

  assign key_code  = key_code_r;
  assign key_ext   = key_ext_r;
  assign key_break = key_break_r;
  assign key_valid = key_valid_r;
  assign frame_err = frame_err_r;
  assign btn_A     = btn_a_r;
  assign btn_B     = btn_b_r;
  assign btn_C     = btn_c_r;
  assign btn_D     = btn_d_r;

  logic unused_s;
  assign unused_s = clk_level_s;

endmodule

// File: doc/ps2_keyboard_rx.md
Name: ps2_keyboard_rx

Overview:
- Input-side counterpart to the game's VGA/pixel output path: receives PS/2 keyboard frames from a real keyboard and decodes scan-code set 2.
- Produces key events plus held-level button signals btn_A..btn_D that drive the existing player ship, shot and restart logic in place of the push buttons.
- Sits at top level between the PS/2 pins and the game modules, in the 50 MHz clk domain.

Parameters:
- FILTER_LEN, 8: consecutive equal synchronized samples required before the filtered ps2_clk changes.
- TIMEOUT_CYCLES, 50000: idle clk cycles mid-frame before abort (1 ms at 50 MHz).
- KEY_A_CODE, 8'h6B / KEY_A_EXT, 1: left arrow, drives btn_A.
- KEY_B_CODE, 8'h74 / KEY_B_EXT, 1: right arrow, drives btn_B.
- KEY_C_CODE, 8'h76 / KEY_C_EXT, 0: Esc, drives btn_C.
- KEY_D_CODE, 8'h29 / KEY_D_EXT, 0: Space (fire/restart), drives btn_D.

Ports:
- clk  in  1  system clock, 50 MHz.
- reset  in  1  synchronous, active-high.
- ps2_clk  in  1  raw PS/2 clock pin, asynchronous.
- ps2_data  in  1  raw PS/2 data pin, asynchronous.
- key_code  out  8  last decoded scan code, excluding prefixes.
- key_ext  out  1  key_code was preceded by E0.
- key_break  out  1  key_code was preceded by F0 (release).
- key_valid  out  1  one-cycle strobe: key_code/key_ext/key_break updated.
- frame_err  out  1  one-cycle strobe: parity, start, stop or timeout error.
- btn_A, btn_B, btn_C, btn_D  out  1 each  held level, 1 while the mapped key is pressed.

Behaviour:
- Interface: reset reset, synchronous, active-high; clock clk.
- Reset values:
  - All outputs are 0.
  - The bit FSM is in IDLE.
  - ext_pend and brk_pend are 0.
  - The filter output is 1, and the synchronizers are preset to 1.
- Input conditioning:
  - Both pins pass through 2-FF synchronizers.
  - ps2_clk is also filtered: the filtered value changes only after FILTER_LEN consecutive identical samples.
  - fall is a one-cycle pulse on a filtered 1->0 transition.
  - ps2_data is sampled, synchronized, on fall.
- Bit FSM: IDLE -> DATA -> PARITY -> STOP.
  - IDLE: on fall with data=0 go to DATA, clear the bit count. On fall with data=1, stay in IDLE and pulse frame_err.
  - DATA: shift 8 bits LSB first on each fall. After the 8th bit go to PARITY.
  - PARITY: capture the bit. Odd parity is required: XOR of the 8 data bits and the parity bit must equal 1.
  - STOP: on fall, if stop=1 and parity is OK, emit the byte. Otherwise pulse frame_err. Go to IDLE.
  - Timeout: outside IDLE, a counter runs and is cleared on every fall. When it reaches TIMEOUT_CYCLES-1, pulse frame_err and go to IDLE.
- Byte layer, one cycle after the STOP fall:
  - 8'hE0: set ext_pend, no key_valid.
  - 8'hF0: set brk_pend, no key_valid.
  - Any other byte:
    - Set key_code=byte, key_ext=ext_pend, key_break=brk_pend.
    - Pulse key_valid.
    - Clear both pend flags.
  - key_code, key_ext and key_break hold until the next key_valid.
  - Any frame_err clears both pend flags.
- Button mapping, registered in the same cycle as key_valid:
  - If {key_ext, key_code} matches {KEY_x_EXT, KEY_x_CODE}, btn_x <= ~key_break.
  - Typematic repeat of a make code keeps btn_x=1, and key_valid still pulses each time.
  - A break for a key that is not pressed leaves btn_x=0.
  - Ext must match exactly: 8'h6B without E0 (keypad 4) does not drive btn_A.
- Latency: key_valid asserts exactly 1 clk after the fall pulse of the stop bit.
- Reset mid-frame: the frame is discarded and all state returns to reset values; no strobes occur.
- Simultaneous events: fall coincident with timeout expiry means fall wins and the counter clears.

Decomposition:
- Package ps2_pkg:
  - Bit-FSM state enum.
  - Prefix constants PS2_EXT=8'hE0 and PS2_BRK=8'hF0.
  - Default key-code constants.
- One sub-module, ps2_line_filter: 2-FF synchronizer plus FILTER_LEN glitch filter, outputs clean level and fall pulse. Instantiated for ps2_clk; ps2_data uses only the synchronizer.

Test Plan:
- Space frame 8'h29, parity 0 -> key_valid one pulse, key_code=8'h29, ext=0, break=0, btn_D=1. Then F0 29 -> key_break=1, btn_D=0.
- E0 6B make, then E0 F0 6B break -> btn_A 1 then 0, key_ext=1 both times; exactly 2 key_valid pulses total.
- Frame 8'h1C with a wrong parity bit -> frame_err one pulse, no key_valid, buttons unchanged. The next valid frame decodes normally.
- Start bit then 4 data bits, then silence for 50000 cycles -> frame_err pulse, FSM in IDLE. A following 8'h76 frame sets btn_C=1.
- 3-cycle glitch pulses on ps2_clk with FILTER_LEN=8 -> no bit shifted. Reset asserted mid-frame with btn_B=1 -> all outputs 0 the next cycle.
- 8'h6B without E0 -> key_valid pulses, btn_A stays 0. Ten repeated E0 74 makes -> btn_B stays 1, 10 key_valid pulses.
